// File: rtl/sram_ctl.sv
// Controller for an external asynchronous SRAM behind SB_IO pin buffers.
// Turns valid/ready requests into registered, glitch-free strobe sequences with programmable timing.
module sram_ctl #(
   parameter int ADDR_W   = 19,
   parameter int DATA_W   = 8,
   parameter int RD_WAIT  = 2,
   parameter int WR_SETUP = 1,
   parameter int WR_PULSE = 2,
   parameter int WR_HOLD  = 1,
   parameter int TURN     = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic [DATA_W-1:0] sram_dout,
   output logic              sram_doe,
   input  logic [DATA_W-1:0] sram_din
);

   localparam int MAX_A = (RD_WAIT  > WR_SETUP) ? RD_WAIT  : WR_SETUP;
   localparam int MAX_B = (WR_PULSE > WR_HOLD)  ? WR_PULSE : WR_HOLD;
   localparam int MAX_C = (MAX_A    > MAX_B)    ? MAX_A    : MAX_B;
   localparam int MAX_T = (MAX_C    > TURN)     ? MAX_C    : TURN;
   localparam int CNT_W = (MAX_T < 2) ? 1 : $clog2(MAX_T + 1);

   // Each phase loads its length minus one; the phase ends on the edge where the counter is zero.
   localparam logic [CNT_W-1:0] RD_LD = CNT_W'((RD_WAIT  > 0) ? RD_WAIT  - 1 : 0);
   localparam logic [CNT_W-1:0] SU_LD = CNT_W'((WR_SETUP > 0) ? WR_SETUP - 1 : 0);
   localparam logic [CNT_W-1:0] PU_LD = CNT_W'((WR_PULSE > 0) ? WR_PULSE - 1 : 0);
   localparam logic [CNT_W-1:0] HD_LD = CNT_W'((WR_HOLD  > 0) ? WR_HOLD  - 1 : 0);
   localparam logic [CNT_W-1:0] TN_LD = CNT_W'((TURN     > 0) ? TURN     - 1 : 0);

   if (RD_WAIT < 1) begin : g_bad_rd_wait
      $error("sram_ctl: RD_WAIT must be at least 1");
   end
   if (WR_PULSE < 1) begin : g_bad_wr_pulse
      $error("sram_ctl: WR_PULSE must be at least 1");
   end
   if (WR_SETUP < 0 || WR_HOLD < 0 || TURN < 0) begin : g_bad_negative
      $error("sram_ctl: WR_SETUP, WR_HOLD and TURN must not be negative");
   end

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WSU,
      WPU,
      WHD,
      TRN
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // NOTE: every output is a flop updated with non-blocking assignments, so the
   // SRAM pins only change right after a clock edge and can never glitch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         sram_addr <= '0;
         sram_dout <= '0;
         sram_ce_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_we_n <= 1'b1;
         sram_doe  <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  sram_addr <= req_addr;
                  sram_dout <= req_wdata;
                  sram_ce_n <= 1'b0;
                  if (!req_we) begin
                     state     <= RD;
                     sram_oe_n <= 1'b0;
                     cnt       <= RD_LD;
                  end else begin
                     sram_doe <= 1'b1;
                     if (WR_SETUP > 0) begin
                        state <= WSU;
                        cnt   <= SU_LD;
                     end else begin
                        state     <= WPU;
                        sram_we_n <= 1'b0;
                        cnt       <= PU_LD;
                     end
                  end
               end
            end

            RD: begin
               if (cnt == '0) begin
                  rsp_rdata <= sram_din;
                  rsp_valid <= 1'b1;
                  sram_oe_n <= 1'b1;
                  sram_ce_n <= 1'b1;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            WSU: begin
               if (cnt == '0) begin
                  state     <= WPU;
                  sram_we_n <= 1'b0;
                  cnt       <= PU_LD;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            WPU: begin
               if (cnt == '0) begin
                  sram_we_n <= 1'b1;
                  if (WR_HOLD > 0) begin
                     state <= WHD;
                     cnt   <= HD_LD;
                  end else if (TURN > 0) begin
                     state     <= TRN;
                     sram_doe  <= 1'b0;
                     sram_ce_n <= 1'b1;
                     cnt       <= TN_LD;
                  end else begin
                     state     <= IDLE;
                     sram_doe  <= 1'b0;
                     sram_ce_n <= 1'b1;
                     req_ready <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            WHD: begin
               if (cnt == '0) begin
                  sram_doe  <= 1'b0;
                  sram_ce_n <= 1'b1;
                  if (TURN > 0) begin
                     state <= TRN;
                     cnt   <= TN_LD;
                  end else begin
                     state     <= IDLE;
                     req_ready <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            TRN: begin
               if (cnt == '0) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            default: begin
               state     <= IDLE;
               req_ready <= 1'b0;
               sram_ce_n <= 1'b1;
               sram_oe_n <= 1'b1;
               sram_we_n <= 1'b1;
               sram_doe  <= 1'b0;
            end
         endcase
      end
   end

   // Bus-contention and strobe-placement invariants of the pin sequencing.
   a_no_oe_we_overlap : assert property (@(posedge clk) disable iff (!reset_n)
      !(!sram_oe_n && !sram_we_n));
   a_drive_implies_no_oe : assert property (@(posedge clk) disable iff (!reset_n)
      sram_doe |-> sram_oe_n);
   a_we_only_in_pulse : assert property (@(posedge clk) disable iff (!reset_n)
      !sram_we_n |-> (state == WPU));
   a_ready_only_idle : assert property (@(posedge clk) disable iff (!reset_n)
      req_ready |-> (state == IDLE));

endmodule

// File: tb/tb_sram_ctl.sv
// Directed bench for sram_ctl: a vector table of reads/writes against a byte-array SRAM model,
// plus hand-written sequences for back-to-back requests and reset during a write pulse.
module tb_sram_ctl;

   localparam int ADDR_W   = 19;
   localparam int DATA_W   = 8;
   localparam int RD_WAIT  = 2;
   localparam int WR_SETUP = 1;
   localparam int WR_PULSE = 2;
   localparam int WR_HOLD  = 1;
   localparam int TURN     = 1;
   localparam int WR_ACT   = WR_SETUP + WR_PULSE + WR_HOLD;

   logic              clk;
   logic              reset_n;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic [ADDR_W-1:0] sram_addr;
   logic              sram_ce_n;
   logic              sram_oe_n;
   logic              sram_we_n;
   logic [DATA_W-1:0] sram_dout;
   logic              sram_doe;
   logic [DATA_W-1:0] sram_din;

   int total   = 0;
   int bad     = 0;
   int inv_bad = 0;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] exp_rdata;
   } vec_t;

   vec_t vecs [7];

   sram_ctl #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .RD_WAIT (RD_WAIT),
      .WR_SETUP(WR_SETUP),
      .WR_PULSE(WR_PULSE),
      .WR_HOLD (WR_HOLD),
      .TURN    (TURN)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we   (req_we),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .sram_addr(sram_addr),
      .sram_ce_n(sram_ce_n),
      .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n),
      .sram_dout(sram_dout),
      .sram_doe (sram_doe),
      .sram_din (sram_din)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Asynchronous SRAM: data appears only while selected and output-enabled.
   assign sram_din = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'hEE;

   always @(posedge sram_we_n) begin
      if (reset_n && !sram_ce_n && sram_doe) mem[sram_addr] = sram_dout;
   end

   always @(negedge clk) begin
      if (reset_n) begin
         if (!sram_oe_n && !sram_we_n) inv_bad++;
         if (sram_doe && !sram_oe_n)   inv_bad++;
         if (!sram_we_n && !sram_doe)  inv_bad++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] status();
      return {sram_doe, sram_we_n, sram_oe_n, sram_ce_n, req_ready, rsp_valid};
   endfunction

   function automatic logic [5:0] wr_exp(input int c);
      logic act;
      act = (c <= WR_ACT);
      return {act, !(c > WR_SETUP && c <= WR_SETUP + WR_PULSE), 1'b1, !act,
              (c > WR_ACT + TURN), 1'b0};
   endfunction

   function automatic logic [5:0] rd_exp(input int c);
      logic act;
      act = (c <= RD_WAIT);
      return {1'b0, 1'b1, !act, !act, (c > RD_WAIT), (c == RD_WAIT + 1)};
   endfunction

   task automatic wait_ready();
      for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
      check("ready_wait", req_ready, 1);
   endtask

   // Issue one request at a negedge; returns positioned at the negedge of cycle 1.
   task automatic issue(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
      wait_ready();
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int n;
      issue(v.we, v.addr, v.wdata);
      req_valid = 1'b0;
      n = v.we ? (WR_ACT + TURN + 1) : (RD_WAIT + 2);
      for (int c = 1; c <= n; c++) begin
         if (v.we) begin
            check($sformatf("v%0d_wr_st_c%0d", idx, c), status(), wr_exp(c));
            if (c <= WR_ACT) check($sformatf("v%0d_wr_addr_c%0d", idx, c), sram_addr, v.addr);
            if (c == 1)      check($sformatf("v%0d_wr_dout", idx), sram_dout, v.wdata);
         end else begin
            check($sformatf("v%0d_rd_st_c%0d", idx, c), status(), rd_exp(c));
            if (c <= RD_WAIT) check($sformatf("v%0d_rd_addr_c%0d", idx, c), sram_addr, v.addr);
            if (c >= RD_WAIT + 1) check($sformatf("v%0d_rd_data_c%0d", idx, c), rsp_rdata, v.exp_rdata);
         end
         if (c < n) @(negedge clk);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      mem[19'h01000] = 8'h3C;
      mem[19'h00000] = 8'h11;

      vecs[0] = '{1'b1, 19'h12345, 8'hA5, 8'h00};
      vecs[1] = '{1'b0, 19'h12345, 8'h00, 8'hA5};
      vecs[2] = '{1'b0, 19'h01000, 8'h00, 8'h3C};
      vecs[3] = '{1'b1, 19'h7FFFF, 8'h5A, 8'h00};
      vecs[4] = '{1'b0, 19'h7FFFF, 8'h00, 8'h5A};
      vecs[5] = '{1'b0, 19'h00000, 8'h00, 8'h11};
      vecs[6] = '{1'b1, 19'h00055, 8'hC3, 8'h00};

      // Reset held for five clocks.
      repeat (5) @(negedge clk);
      check("rst_status", status(), 6'b011100);
      check("rst_addr", sram_addr, 0);
      check("rst_dout", sram_dout, 0);
      check("rst_rdata", rsp_rdata, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_first_ready", req_ready, 1);

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);
      run_vec(7, '{1'b0, 19'h00055, 8'h00, 8'hC3});

      // Request held during a read with a new payload: accepted only once the read completes.
      issue(1'b0, 19'h01000, 8'h00);
      req_addr = 19'h00000;
      for (int c = 1; c <= 2 * RD_WAIT + 3; c++) begin
         if (c <= RD_WAIT) begin
            check($sformatf("b2b_busy_c%0d", c), {req_ready, rsp_valid}, 2'b00);
            check($sformatf("b2b_addr_c%0d", c), sram_addr, 19'h01000);
         end else if (c == RD_WAIT + 1) begin
            check("b2b_rsp1", {req_ready, rsp_valid, rsp_rdata}, {2'b11, 8'h3C});
         end else if (c == RD_WAIT + 2) begin
            check("b2b_second_addr", sram_addr, 19'h00000);
            check("b2b_second_st", {sram_oe_n, rsp_valid, req_ready, rsp_rdata}, {3'b000, 8'h3C});
            req_valid = 1'b0;
         end else if (c == 2 * RD_WAIT + 2) begin
            check("b2b_rsp2", {rsp_valid, rsp_rdata}, {1'b1, 8'h11});
         end else if (c == 2 * RD_WAIT + 3) begin
            check("b2b_rsp2_end", {req_ready, rsp_valid}, 2'b10);
         end
         @(negedge clk);
      end

      // Reset asserted while we_n is low.
      issue(1'b1, 19'h00100, 8'h77);
      req_valid = 1'b0;
      for (int c = 1; c <= WR_SETUP + 1; c++) begin
         if (c > 1) @(negedge clk);
      end
      check("mr_we_low", sram_we_n, 0);
      reset_n = 1'b0;
      #1;
      check("mr_async", status(), 6'b011100);
      repeat (2) @(negedge clk);
      check("mr_held", status(), 6'b011100);
      reset_n = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check($sformatf("mr_after_c%0d", c), status(), 6'b011110);
      end

      check("invariants", inv_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
